// File: rtl/barrel_shifter_pkg.sv
// barrel_shifter_pkg: shared widths and aluc op codes for the 32-bit barrel shifter
package barrel_shifter_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLA = 2'b10;
    localparam logic [1:0] OP_SLL = 2'b11;
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one fixed-distance stage of the shift network, bypassed when not enabled
import barrel_shifter_pkg::*;
module barrel_stage #(
    parameter int SH = 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              en_i,
    input  logic              left_i,
    input  logic              fill_i,
    output logic [DATA_W-1:0] data_o
);
    // fill_i is only ever 1 for arithmetic right shifts, so left shifts zero-fill
    assign data_o = !en_i   ? data_i :
                    left_i  ? {data_i[DATA_W-1-SH:0], {SH{fill_i}}} :
                              {{SH{fill_i}}, data_i[DATA_W-1:SH]};
endmodule

// File: rtl/barrel_shifter32.sv
// barrel_shifter32: registered SRA/SRL/SLL shifter; BSH_PIPE2_EN adds a register after the shift-by-8 stage
import barrel_shifter_pkg::*;
module barrel_shifter32 (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [1:0]         aluc,
    output logic               out_valid,
    output logic [DATA_W-1:0]  c
);
    logic              left, fill;
    logic [DATA_W-1:0] s16, s8, s4, s2, s1;
    logic [DATA_W-1:0] mid;
    logic [2:0]        mid_b;
    logic              mid_left, mid_fill, mid_v;
    logic [DATA_W-1:0] c_q, c_d;
    logic              v_q;

    assign left = (aluc == OP_SLA) || (aluc == OP_SLL);
    assign fill = (aluc != OP_SRL) && !left && a[DATA_W-1];

    barrel_stage #(.SH(16)) u_s16 (.data_i(a),   .en_i(b[4]), .left_i(left), .fill_i(fill), .data_o(s16));
    barrel_stage #(.SH(8))  u_s8  (.data_i(s16), .en_i(b[3]), .left_i(left), .fill_i(fill), .data_o(s8));

`ifdef BSH_PIPE2_EN
    logic [DATA_W-1:0] p_q;
    logic [2:0]        pb_q;
    logic              pl_q, pf_q, pv_q;

    // capture partial result and the controls the remaining stages need
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            pb_q <= '0;
            pl_q <= 1'b0;
            pf_q <= 1'b0;
            pv_q <= 1'b0;
        end else begin
            p_q  <= s8;
            pb_q <= b[2:0];
            pl_q <= left;
            pf_q <= fill;
            pv_q <= in_valid;
        end
    end

    assign mid      = p_q;
    assign mid_b    = pb_q;
    assign mid_left = pl_q;
    assign mid_fill = pf_q;
    assign mid_v    = pv_q;
`else
    assign mid      = s8;
    assign mid_b    = b[2:0];
    assign mid_left = left;
    assign mid_fill = fill;
    assign mid_v    = in_valid;
`endif

    barrel_stage #(.SH(4)) u_s4 (.data_i(mid), .en_i(mid_b[2]), .left_i(mid_left), .fill_i(mid_fill), .data_o(s4));
    barrel_stage #(.SH(2)) u_s2 (.data_i(s4),  .en_i(mid_b[1]), .left_i(mid_left), .fill_i(mid_fill), .data_o(s2));
    barrel_stage #(.SH(1)) u_s1 (.data_i(s2),  .en_i(mid_b[0]), .left_i(mid_left), .fill_i(mid_fill), .data_o(s1));

    assign c_d = mid_v ? s1 : c_q;

    // output register: load on valid, otherwise hold the last result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
            v_q <= 1'b0;
        end else begin
            c_q <= c_d;
            v_q <= mid_v;
        end
    end

    assign c         = c_q;
    assign out_valid = v_q;
endmodule

// File: tb/tb_barrel_shifter32.sv
// tb_barrel_shifter32: directed table-driven checks of barrel_shifter32 (honours BSH_PIPE2_EN)
module tb_barrel_shifter32;
`ifdef BSH_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [4:0]  b = '0;
    logic [1:0]  aluc = '0;
    logic        out_valid;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;

    barrel_shifter32 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .aluc(aluc), .out_valid(out_valid), .c(c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        @(negedge clk);
        a = v.a; b = v.b; aluc = v.op; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check({name, " c"}, c, v.exp);
        check({name, " valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    vec_t tbl[$];
    vec_t stream[4];

    initial begin
        tbl = '{
            '{32'hFFFF0000, 5'd10, 2'b00, 32'hFFFFFFC0},
            '{32'hFFFF0000, 5'd10, 2'b01, 32'h003FFFC0},
            '{32'hFFFF0000, 5'd10, 2'b10, 32'hFC000000},
            '{32'hFFFF0000, 5'd10, 2'b11, 32'hFC000000},
            '{32'hFFFF0000, 5'd16, 2'b00, 32'hFFFFFFFF},
            '{32'hFFFF0000, 5'd16, 2'b01, 32'h0000FFFF},
            '{32'hFFFF0000, 5'd16, 2'b10, 32'h00000000},
            '{32'hFFFF0000, 5'd16, 2'b11, 32'h00000000},
            '{32'hFFFF0000, 5'd4,  2'b00, 32'hFFFFF000},
            '{32'hFFFF0000, 5'd4,  2'b01, 32'h0FFFF000},
            '{32'hFFFF0000, 5'd4,  2'b10, 32'hFFF00000},
            '{32'hFFFF0000, 5'd4,  2'b11, 32'hFFF00000},
            '{32'h7FFFFFFF, 5'd31, 2'b00, 32'h00000000},
            '{32'h7FFFFFFF, 5'd31, 2'b01, 32'h00000000},
            '{32'h80000000, 5'd31, 2'b00, 32'hFFFFFFFF},
            '{32'h80000000, 5'd31, 2'b01, 32'h00000001},
            '{32'h00000001, 5'd31, 2'b11, 32'h80000000},
            '{32'h00000001, 5'd31, 2'b10, 32'h80000000},
            '{32'h80000001, 5'd0,  2'b00, 32'h80000001},
            '{32'h80000001, 5'd0,  2'b01, 32'h80000001},
            '{32'h80000001, 5'd0,  2'b10, 32'h80000001},
            '{32'h80000001, 5'd0,  2'b11, 32'h80000001},
            '{32'h12345678, 5'd1,  2'b11, 32'h2468ACF0},
            '{32'h12345678, 5'd8,  2'b01, 32'h00123456},
            '{32'h92345678, 5'd3,  2'b00, 32'hF2468ACF}
        };
        stream = '{
            '{32'hF0000000, 5'd2,  2'b00, 32'hFC000000},
            '{32'hF0000000, 5'd2,  2'b01, 32'h3C000000},
            '{32'h0000000F, 5'd28, 2'b11, 32'hF0000000},
            '{32'hDEADBEEF, 5'd0,  2'b01, 32'hDEADBEEF}
        };

        #12;
        check("reset c", c, 32'h0);
        check("reset valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_op($sformatf("vec%0d", i), tbl[i]);

        for (int k = 0; k < 4 + LAT; k++) begin
            int j;
            @(negedge clk);
            if (k < 4) begin
                a = stream[k].a; b = stream[k].b; aluc = stream[k].op; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0; a = 32'h55555555; b = 5'd7; aluc = 2'b11;
            end
            @(posedge clk);
            #1;
            j = k - LAT + 1;
            if (j >= 0 && j < 4) begin
                check($sformatf("stream%0d c", j), c, stream[j].exp);
                check($sformatf("stream%0d valid", j), {31'b0, out_valid}, 32'd1);
            end else if (j == 4) begin
                check("hold c", c, stream[3].exp);
                check("hold valid", {31'b0, out_valid}, 32'd0);
            end
        end

        @(negedge clk);
        a = 32'hFFFF0000; b = 5'd4; aluc = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async reset c", c, 32'h0);
        check("async reset valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        check("post-reset idle valid", {31'b0, out_valid}, 32'd0);
        check("post-reset idle c", c, 32'h0);
        run_op("after reset", '{32'hFFFF0000, 5'd10, 2'b01, 32'h003FFFC0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
